psram_arbiter: RTL and testbench

Two-requester arbiter that shares the single PSRAM peripheral port between the CPU bus master and the display line-fetch engine. It sits between those masters and the PSRAM controller, serialises whole transactions (one outstanding at a time), and returns read data and completion to the owning master. The display fetcher has priority, with a bounded-starvation rule guaranteeing CPU progress.

---
 rtl/psram_arb_pkg.sv | 30 +++
 rtl/psram_arbiter_if.sv | 53 +++++
 rtl/psram_arb_watchdog.sv | 48 ++++
 rtl/psram_arbiter.sv | 189 ++++++++++++++++++
 tb/tb_psram_arbiter.sv | 349 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/psram_arb_pkg.sv
// psram_arb_pkg: shared types and constants for the PSRAM two-master arbiter.
//   state_e  - transaction FSM states (IDLE/ISSUE/WAIT/RESP)
//   owner_e  - which master currently owns the PSRAM port
//   ADDR_W / DATA_W - bus widths, ABORT_DATA - read data returned on a watchdog abort
package psram_arb_pkg;

  localparam int ADDR_W = 24;
  localparam int DATA_W = 16;
  localparam logic [DATA_W-1:0] ABORT_DATA = 16'hDEAD;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_e;

  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_VID = 1'b1
  } owner_e;

  // The fetcher normally wins; the CPU wins when the fetcher is idle or when the
  // fetcher has used up its allowance of consecutive grants while the CPU waited.
  function automatic logic cpu_wins(input logic cpu_req, input logic vid_req,
                                    input logic streak_full);
    return cpu_req & (~vid_req | streak_full);
  endfunction

endpackage

// File: rtl/psram_arbiter_if.sv
// psram_arbiter_if: bundle of the CPU, display-fetcher and PSRAM-controller signals
// around the arbiter.
//   slave  modport - arbiter side (takes i_* in, drives o_*)
//   master modport - environment side (drives i_*, observes o_*)
interface psram_arbiter_if;

  logic                              i_cpu_req;
  logic                              i_cpu_we;
  logic [psram_arb_pkg::ADDR_W-1:0]  i_cpu_addr;
  logic [psram_arb_pkg::DATA_W-1:0]  i_cpu_wdata;
  logic                              o_cpu_gnt;
  logic                              o_cpu_done;
  logic [psram_arb_pkg::DATA_W-1:0]  o_cpu_rdata;

  logic                              i_vid_req;
  logic                              i_vid_we;
  logic [psram_arb_pkg::ADDR_W-1:0]  i_vid_addr;
  logic [psram_arb_pkg::DATA_W-1:0]  i_vid_wdata;
  logic                              o_vid_gnt;
  logic                              o_vid_done;
  logic [psram_arb_pkg::DATA_W-1:0]  o_vid_rdata;

  logic                              o_ps_stb;
  logic                              o_ps_we;
  logic [psram_arb_pkg::ADDR_W-1:0]  o_ps_addr;
  logic [psram_arb_pkg::DATA_W-1:0]  o_ps_din;
  logic                              i_ps_busy;
  logic                              i_ps_done;
  logic [psram_arb_pkg::DATA_W-1:0]  i_ps_dout;

  logic                              o_err;

  modport slave (
    input  i_cpu_req, i_cpu_we, i_cpu_addr, i_cpu_wdata,
    output o_cpu_gnt, o_cpu_done, o_cpu_rdata,
    input  i_vid_req, i_vid_we, i_vid_addr, i_vid_wdata,
    output o_vid_gnt, o_vid_done, o_vid_rdata,
    output o_ps_stb, o_ps_we, o_ps_addr, o_ps_din,
    input  i_ps_busy, i_ps_done, i_ps_dout,
    output o_err
  );

  modport master (
    output i_cpu_req, i_cpu_we, i_cpu_addr, i_cpu_wdata,
    input  o_cpu_gnt, o_cpu_done, o_cpu_rdata,
    output i_vid_req, i_vid_we, i_vid_addr, i_vid_wdata,
    input  o_vid_gnt, o_vid_done, o_vid_rdata,
    input  o_ps_stb, o_ps_we, o_ps_addr, o_ps_din,
    output i_ps_busy, i_ps_done, i_ps_dout,
    input  o_err
  );

endinterface

// File: rtl/psram_arb_watchdog.sv
// psram_arb_watchdog: counts cycles spent waiting for the PSRAM controller.
//   clk_100mhz, rstn_i - clock, asynchronous active-low reset
//   load_i   - clear the count (start of a transaction)
//   count_i  - advance the count by one this cycle
//   expire_o - registered; high once TIMEOUT-1 counted cycles have elapsed, so the
//              owner sees the abort on the TIMEOUT-th waiting cycle
module psram_arb_watchdog #(
  parameter int TIMEOUT = 255
) (
  input  logic clk_100mhz,
  input  logic rstn_i,
  input  logic load_i,
  input  logic count_i,
  output logic expire_o
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             expire_q, expire_d;

  // Next count: clear on load, saturate at the limit, otherwise step when counting.
  always_comb begin
    if (load_i) begin
      cnt_d = {CNT_W{1'b0}};
    end else if (count_i && (cnt_q != LIMIT)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
    expire_d = (cnt_d == LIMIT);
  end

  // Count and expiry flags.
  always_ff @(posedge clk_100mhz or negedge rstn_i) begin
    if (!rstn_i) begin
      cnt_q    <= {CNT_W{1'b0}};
      expire_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      expire_q <= expire_d;
    end
  end

  assign expire_o = expire_q;

endmodule

// File: rtl/psram_arbiter.sv
// psram_arbiter: shares one PSRAM controller port between the CPU and the display
// line fetcher, one whole transaction at a time.
//   clk_100mhz, rstn_i - clock, asynchronous active-low reset (shared with the controller)
//   bus (psram_arbiter_if.slave) - CPU and fetcher request/grant/done/data, PSRAM
//        strobe/operands/busy/done/data, and the o_err abort pulse
// The fetcher has priority; after MAX_BURST consecutive fetcher grants taken while
// the CPU was requesting, the CPU is granted next.
// Optional build macro PSRAM_ARB_TIMEOUT_EN: adds a watchdog that aborts a WAIT after
// TIMEOUT cycles, returning ABORT_DATA to the owner and pulsing o_err. Without it the
// wait is unbounded and o_err stays low.
module psram_arbiter
  import psram_arb_pkg::*;
#(
  parameter int MAX_BURST = 4,
  parameter int TIMEOUT   = 255
) (
  input  logic           clk_100mhz,
  input  logic           rstn_i,
  psram_arbiter_if.slave bus
);

  localparam logic [2:0] STREAK_MAX = 3'(MAX_BURST);

  state_e              state_q, state_d;
  owner_e              owner_q, owner_d;
  logic [2:0]          streak_q, streak_d;
  logic                cpu_gnt_q, cpu_gnt_d, vid_gnt_q, vid_gnt_d;
  logic                cpu_done_q, cpu_done_d, vid_done_q, vid_done_d;
  logic [DATA_W-1:0]   cpu_rdata_q, cpu_rdata_d, vid_rdata_q, vid_rdata_d;
  logic                ps_stb_q, ps_stb_d, ps_we_q, ps_we_d;
  logic [ADDR_W-1:0]   ps_addr_q, ps_addr_d;
  logic [DATA_W-1:0]   ps_din_q, ps_din_d;
  logic                err_q, err_d;
  logic                wd_load_s, wd_count_s, wd_expire_s;

  // Transaction FSM next-state, arbitration and response capture.
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    streak_d    = streak_q;
    cpu_gnt_d   = cpu_gnt_q;
    vid_gnt_d   = vid_gnt_q;
    cpu_done_d  = 1'b0;
    vid_done_d  = 1'b0;
    cpu_rdata_d = cpu_rdata_q;
    vid_rdata_d = vid_rdata_q;
    ps_stb_d    = 1'b0;
    ps_we_d     = ps_we_q;
    ps_addr_d   = ps_addr_q;
    ps_din_d    = ps_din_q;
    err_d       = 1'b0;
    wd_load_s   = 1'b0;
    wd_count_s  = 1'b0;
    case (state_q)
      IDLE: begin
        if ((bus.i_cpu_req || bus.i_vid_req) && !bus.i_ps_busy) begin
          ps_stb_d = 1'b1;
          state_d  = ISSUE;
          if (cpu_wins(bus.i_cpu_req, bus.i_vid_req, streak_q >= STREAK_MAX)) begin
            owner_d   = OWN_CPU;
            cpu_gnt_d = 1'b1;
            ps_we_d   = bus.i_cpu_we;
            ps_addr_d = bus.i_cpu_addr;
            ps_din_d  = bus.i_cpu_wdata;
            streak_d  = 3'd0;
          end else begin
            owner_d   = OWN_VID;
            vid_gnt_d = 1'b1;
            ps_we_d   = bus.i_vid_we;
            ps_addr_d = bus.i_vid_addr;
            ps_din_d  = bus.i_vid_wdata;
            // Only grants taken at the CPU's expense count towards the streak.
            if (bus.i_cpu_req) begin
              streak_d = streak_q + 3'd1;
            end else begin
              streak_d = 3'd0;
            end
          end
        end else begin
          state_d = IDLE;
        end
      end
      ISSUE: begin
        wd_load_s = 1'b1;
        state_d   = WAIT;
      end
      WAIT: begin
        wd_count_s = 1'b1;
        if (bus.i_ps_done) begin
          state_d = RESP;
          if (owner_q == OWN_CPU) begin
            cpu_rdata_d = bus.i_ps_dout;
            cpu_done_d  = 1'b1;
          end else begin
            vid_rdata_d = bus.i_ps_dout;
            vid_done_d  = 1'b1;
          end
        end else if (wd_expire_s) begin
          state_d = RESP;
          err_d   = 1'b1;
          if (owner_q == OWN_CPU) begin
            cpu_rdata_d = ABORT_DATA;
            cpu_done_d  = 1'b1;
          end else begin
            vid_rdata_d = ABORT_DATA;
            vid_done_d  = 1'b1;
          end
        end else begin
          state_d = WAIT;
        end
      end
      RESP: begin
        cpu_gnt_d = 1'b0;
        vid_gnt_d = 1'b0;
        state_d   = IDLE;
      end
      default: begin
        cpu_gnt_d = 1'b0;
        vid_gnt_d = 1'b0;
        state_d   = IDLE;
      end
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk_100mhz or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q     <= IDLE;
      owner_q     <= OWN_CPU;
      streak_q    <= 3'd0;
      cpu_gnt_q   <= 1'b0;
      vid_gnt_q   <= 1'b0;
      cpu_done_q  <= 1'b0;
      vid_done_q  <= 1'b0;
      cpu_rdata_q <= 16'h0000;
      vid_rdata_q <= 16'h0000;
      ps_stb_q    <= 1'b0;
      ps_we_q     <= 1'b0;
      ps_addr_q   <= 24'h000000;
      ps_din_q    <= 16'h0000;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      streak_q    <= streak_d;
      cpu_gnt_q   <= cpu_gnt_d;
      vid_gnt_q   <= vid_gnt_d;
      cpu_done_q  <= cpu_done_d;
      vid_done_q  <= vid_done_d;
      cpu_rdata_q <= cpu_rdata_d;
      vid_rdata_q <= vid_rdata_d;
      ps_stb_q    <= ps_stb_d;
      ps_we_q     <= ps_we_d;
      ps_addr_q   <= ps_addr_d;
      ps_din_q    <= ps_din_d;
      err_q       <= err_d;
    end
  end

`ifdef PSRAM_ARB_TIMEOUT_EN
  psram_arb_watchdog #(
    .TIMEOUT(TIMEOUT)
  ) u_watchdog (
    .clk_100mhz(clk_100mhz),
    .rstn_i    (rstn_i),
    .load_i    (wd_load_s),
    .count_i   (wd_count_s),
    .expire_o  (wd_expire_s)
  );
`else
  // No watchdog: the wait never aborts, so err_q can never be set.
  logic [33:0] timeout_unused_s;
  assign wd_expire_s      = 1'b0;
  assign timeout_unused_s = {wd_load_s, wd_count_s, 32'(TIMEOUT)};
`endif

  assign bus.o_cpu_gnt   = cpu_gnt_q;
  assign bus.o_cpu_done  = cpu_done_q;
  assign bus.o_cpu_rdata = cpu_rdata_q;
  assign bus.o_vid_gnt   = vid_gnt_q;
  assign bus.o_vid_done  = vid_done_q;
  assign bus.o_vid_rdata = vid_rdata_q;
  assign bus.o_ps_stb    = ps_stb_q;
  assign bus.o_ps_we     = ps_we_q;
  assign bus.o_ps_addr   = ps_addr_q;
  assign bus.o_ps_din    = ps_din_q;
  assign bus.o_err       = err_q;

endmodule

// File: tb/tb_psram_arbiter.sv
// tb_psram_arbiter: directed scoreboard bench for psram_arbiter. Stimulus pushes the
// expected PSRAM issue and the expected completion of every transaction; a monitor
// pops and compares whenever the arbiter strobes the controller or pulses a done.
// A small controller model answers each strobe after ps_lat cycles with either a fixed
// word or (address[15:0] ^ 16'h5A5A).
module tb_psram_arbiter;
  import psram_arb_pkg::*;

  logic clk_100mhz = 1'b0;
  logic rstn_i     = 1'b1;
  always #5 clk_100mhz = ~clk_100mhz;

  psram_arbiter_if bus();

  psram_arbiter #(
    .MAX_BURST(4),
    .TIMEOUT  (255)
  ) dut (
    .clk_100mhz(clk_100mhz),
    .rstn_i    (rstn_i),
    .bus       (bus)
  );

  typedef struct packed {
    logic        own_cpu;
    logic        we;
    logic [23:0] addr;
    logic [15:0] din;
  } stb_exp_t;

  typedef struct packed {
    logic        own_cpu;
    logic [15:0] rdata;
    logic        err;
  } done_exp_t;

  stb_exp_t  stb_q[$];
  done_exp_t done_q[$];
  int        n_vec = 0;
  int        n_bad = 0;

  // Controller model knobs.
  int          ps_lat      = 6;
  logic        ps_mute     = 1'b0;
  logic        ps_fixed_en = 1'b0;
  logic [15:0] ps_fixed    = 16'h0000;
  int          ps_cnt      = 0;

  function automatic logic [78:0] all_outs();
    return {bus.o_cpu_gnt, bus.o_vid_gnt, bus.o_cpu_done, bus.o_vid_done,
            bus.o_cpu_rdata, bus.o_vid_rdata, bus.o_ps_stb, bus.o_ps_we,
            bus.o_ps_addr, bus.o_ps_din, bus.o_err};
  endfunction

  // PSRAM controller model: busy from strobe to done, done after ps_lat cycles.
  initial begin
    bus.i_ps_busy = 1'b0;
    bus.i_ps_done = 1'b0;
    bus.i_ps_dout = 16'h0000;
    forever begin
      @(posedge clk_100mhz);
      #1;
      bus.i_ps_done = 1'b0;
      if (!rstn_i) begin
        ps_cnt        = 0;
        bus.i_ps_busy = 1'b0;
      end else begin
        if (ps_cnt > 0) begin
          ps_cnt--;
          if (ps_cnt == 0) begin
            bus.i_ps_done = 1'b1;
            bus.i_ps_dout = ps_fixed_en ? ps_fixed : (bus.o_ps_addr[15:0] ^ 16'h5A5A);
            bus.i_ps_busy = 1'b0;
          end
        end
        if (bus.o_ps_stb && !ps_mute) begin
          ps_cnt        = ps_lat;
          bus.i_ps_busy = 1'b1;
        end
      end
    end
  end

  // Monitor / scoreboard.
  stb_exp_t    cur;
  done_exp_t   dexp;
  logic        active      = 1'b0;
  logic        ps_done_prv = 1'b0;
  logic [15:0] last_cpu_rd = 16'h0000;
  logic [15:0] last_vid_rd = 16'h0000;
  logic [51:0] got_d, req_d;

  initial begin
    forever begin
      @(negedge clk_100mhz);
      if (!rstn_i) begin
        active      = 1'b0;
        ps_done_prv = 1'b0;
        last_cpu_rd = 16'h0000;
        last_vid_rd = 16'h0000;
      end else begin
        if (bus.o_ps_stb) begin
          n_vec++;
          if (stb_q.size() == 0) begin
            n_bad++;
            $display("FAIL stb_unexpected: issued addr %h gnt cpu/vid %b%b, required no issue",
                     bus.o_ps_addr, bus.o_cpu_gnt, bus.o_vid_gnt);
          end else begin
            cur    = stb_q.pop_front();
            active = 1'b1;
            if ({bus.o_cpu_gnt, bus.o_vid_gnt, bus.o_ps_we, bus.o_ps_addr, bus.o_ps_din} !==
                {cur.own_cpu, ~cur.own_cpu, cur.we, cur.addr, cur.din}) begin
              n_bad++;
              $display("FAIL stb_fields: gnt/we/addr/din = %b%b %b %h %h, required %b%b %b %h %h",
                       bus.o_cpu_gnt, bus.o_vid_gnt, bus.o_ps_we, bus.o_ps_addr, bus.o_ps_din,
                       cur.own_cpu, ~cur.own_cpu, cur.we, cur.addr, cur.din);
            end
          end
        end else if (active) begin
          n_vec++;
          if ({bus.o_ps_we, bus.o_ps_addr, bus.o_ps_din} !== {cur.we, cur.addr, cur.din}) begin
            n_bad++;
            $display("FAIL operand_stable: we/addr/din = %b %h %h, required %b %h %h",
                     bus.o_ps_we, bus.o_ps_addr, bus.o_ps_din, cur.we, cur.addr, cur.din);
          end
        end
        if (bus.i_ps_done) begin
          active = 1'b0;
        end

        if (bus.o_cpu_done || bus.o_vid_done) begin
          n_vec++;
          active = 1'b0;
          if (done_q.size() == 0) begin
            n_bad++;
            $display("FAIL done_unexpected: cpu/vid done %b%b, required none",
                     bus.o_cpu_done, bus.o_vid_done);
          end else begin
            dexp  = done_q.pop_front();
            got_d = {bus.o_cpu_done, bus.o_vid_done, bus.o_cpu_rdata, bus.o_vid_rdata,
                     bus.o_err, ps_done_prv | dexp.err};
            req_d = {dexp.own_cpu, ~dexp.own_cpu,
                     dexp.own_cpu ? dexp.rdata : last_cpu_rd,
                     dexp.own_cpu ? last_vid_rd : dexp.rdata,
                     dexp.err, 1'b1};
            if (got_d !== req_d) begin
              n_bad++;
              $display("FAIL done_fields: done cpu/vid, rdata cpu/vid, err, timely = %b%b %h %h %b %b, required %b%b %h %h %b %b",
                       got_d[51], got_d[50], got_d[49:34], got_d[33:18], got_d[1], got_d[0],
                       req_d[51], req_d[50], req_d[49:34], req_d[33:18], req_d[1], req_d[0]);
            end
            if (dexp.own_cpu) last_cpu_rd = dexp.rdata;
            else              last_vid_rd = dexp.rdata;
          end
        end else if (ps_done_prv || bus.o_err) begin
          n_vec++;
          n_bad++;
          $display("FAIL done_missing: no done (err=%b) after controller done=%b, required a done pulse",
                   bus.o_err, ps_done_prv);
        end
        ps_done_prv = bus.i_ps_done;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk_100mhz);
    #1;
  endtask

  task automatic push_txn(input bit cpu, input bit we, input logic [23:0] addr,
                          input logic [15:0] wd, input logic [15:0] rd, input bit err);
    stb_q.push_back(stb_exp_t'{own_cpu: cpu, we: we, addr: addr, din: wd});
    done_q.push_back(done_exp_t'{own_cpu: cpu, rdata: rd, err: err});
  endtask

  // One transaction from an idle arbiter; checks issue latency and done latency.
  task automatic do_txn(input bit cpu, input bit we, input logic [23:0] addr,
                        input logic [15:0] wd, input logic [15:0] rd, input bit err,
                        input int lat_cyc);
    int c;
    bit seen;
    push_txn(cpu, we, addr, wd, rd, err);
    if (cpu) begin
      bus.i_cpu_we = we; bus.i_cpu_addr = addr; bus.i_cpu_wdata = wd; bus.i_cpu_req = 1'b1;
    end else begin
      bus.i_vid_we = we; bus.i_vid_addr = addr; bus.i_vid_wdata = wd; bus.i_vid_req = 1'b1;
    end
    tick(1);
    n_vec++;
    if ({bus.o_ps_stb, bus.o_cpu_gnt, bus.o_vid_gnt} !== {1'b1, cpu, ~cpu}) begin
      n_bad++;
      $display("FAIL issue_latency: stb/cpu_gnt/vid_gnt = %b%b%b, required 1%b%b",
               bus.o_ps_stb, bus.o_cpu_gnt, bus.o_vid_gnt, cpu, ~cpu);
    end
    c = 0;
    seen = 1'b0;
    while (!seen && c < 400) begin
      tick(1);
      c++;
      seen = cpu ? bus.o_cpu_done : bus.o_vid_done;
    end
    n_vec++;
    if (!seen) begin
      n_bad++;
      $display("FAIL done_timeout: no done within %0d cycles, required after %0d", c, lat_cyc);
    end else if (c != lat_cyc) begin
      n_bad++;
      $display("FAIL done_latency: done %0d cycles after stb, required %0d", c, lat_cyc);
    end
    bus.i_cpu_req = 1'b0;
    bus.i_vid_req = 1'b0;
  endtask

  task automatic drain();
    int c = 0;
    while ((stb_q.size() != 0 || done_q.size() != 0) && c < 1000) begin
      tick(1);
      c++;
    end
    tick(2);
    n_vec++;
    if (stb_q.size() != 0 || done_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d issues and %0d dones outstanding, required 0 and 0",
               stb_q.size(), done_q.size());
    end
  endtask

  // Global bound on the run.
  initial begin
    #500000;
    n_bad++;
    $display("FAIL global_timeout: simulation still running, required completion");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  bit          pat[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
  int          nd, cc;
  logic [78:0] outs_s;

  initial begin
    bus.i_cpu_req = 1'b0; bus.i_cpu_we = 1'b0; bus.i_cpu_addr = 24'h000000; bus.i_cpu_wdata = 16'h0000;
    bus.i_vid_req = 1'b0; bus.i_vid_we = 1'b0; bus.i_vid_addr = 24'h000000; bus.i_vid_wdata = 16'h0000;
    #2 rstn_i = 1'b0;
    tick(3);
    n_vec++;
    outs_s = all_outs();
    if (outs_s !== 79'h0) begin
      n_bad++;
      $display("FAIL reset_state: outputs %h, required all zero", outs_s);
    end
    rstn_i = 1'b1;
    tick(2);

    // CPU read returning a fixed word.
    ps_fixed_en = 1'b1;
    ps_fixed    = 16'hBEEF;
    do_txn(1'b1, 1'b0, 24'h000010, 16'h0000, 16'hBEEF, 1'b0, 7);
    drain();
    ps_fixed_en = 1'b0;

    // Fetcher write at the top of the address space.
    do_txn(1'b0, 1'b1, 24'h7FFFFE, 16'h1234, 16'hA5A4, 1'b0, 7);
    drain();

    // Both masters requesting continuously: four fetches, one CPU, repeated.
    for (int i = 0; i < 10; i++) begin
      push_txn(pat[i], 1'b0, pat[i] ? 24'h000200 : 24'h000100, 16'h0000,
               pat[i] ? 16'h585A : 16'h5B5A, 1'b0);
    end
    bus.i_cpu_we = 1'b0; bus.i_cpu_addr = 24'h000200; bus.i_cpu_wdata = 16'h0000;
    bus.i_vid_we = 1'b0; bus.i_vid_addr = 24'h000100; bus.i_vid_wdata = 16'h0000;
    bus.i_cpu_req = 1'b1;
    bus.i_vid_req = 1'b1;
    nd = 0;
    cc = 0;
    while (nd < 10 && cc < 2000) begin
      tick(1);
      cc++;
      if (bus.o_cpu_done || bus.o_vid_done) nd++;
    end
    bus.i_cpu_req = 1'b0;
    bus.i_vid_req = 1'b0;
    drain();

    // CPU request pulsed for one cycle while the fetcher owns the port.
    push_txn(1'b0, 1'b0, 24'h000300, 16'h0000, 16'h595A, 1'b0);
    bus.i_vid_addr = 24'h000300;
    bus.i_vid_req  = 1'b1;
    cc = 0;
    while (!bus.o_vid_gnt && cc < 50) begin
      tick(1);
      cc++;
    end
    bus.i_cpu_addr = 24'h000666;
    bus.i_cpu_req  = 1'b1;
    tick(1);
    bus.i_cpu_req  = 1'b0;
    cc = 0;
    while (!bus.o_vid_done && cc < 400) begin
      tick(1);
      cc++;
    end
    bus.i_vid_req = 1'b0;
    drain();

    // Reset while waiting on the controller, then a normal transaction.
    ps_lat = 20;
    stb_q.push_back(stb_exp_t'{own_cpu: 1'b1, we: 1'b0, addr: 24'h000400, din: 16'h0000});
    bus.i_cpu_addr = 24'h000400;
    bus.i_cpu_req  = 1'b1;
    cc = 0;
    while (!bus.o_ps_stb && cc < 50) begin
      tick(1);
      cc++;
    end
    tick(3);
    #2 rstn_i = 1'b0;
    #1;
    n_vec++;
    outs_s = all_outs();
    if (outs_s !== 79'h0) begin
      n_bad++;
      $display("FAIL reset_in_wait: outputs %h, required all zero", outs_s);
    end
    bus.i_cpu_req = 1'b0;
    tick(3);
    rstn_i = 1'b1;
    ps_lat = 6;
    tick(2);
    do_txn(1'b1, 1'b0, 24'h000400, 16'h0000, 16'h5E5A, 1'b0, 7);
    drain();

`ifdef PSRAM_ARB_TIMEOUT_EN
    // Controller never answers: watchdog abort.
    ps_mute = 1'b1;
    do_txn(1'b1, 1'b0, 24'h000500, 16'h0000, 16'hDEAD, 1'b1, 256);
    drain();
    ps_mute = 1'b0;
`endif

    tick(5);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
